// File: rtl/sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw1r_param
// Description : Parametrised single-clock SRAM with one read/write port and
//               one read-only port. Byte-lane write masks, selectable
//               read-during-write result on port 1, optional output register
//               stage and a post-reset clear sequencer that fills every word
//               with INIT_VALUE before requests are accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw1r_param #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           MASK_GRAN  = 8,
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    RDW_NEW    = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned          NUM_WMASKS = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port 0: read/write
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  // port 1: read only
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  // status
  output logic                  ready,
  output logic                  coll,
  output logic [15:0]           coll_cnt
);

  localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // request decode; nothing is accepted until the clear sweep finishes
  logic run;
  logic wr0;
  logic rd0;
  logic rd1;
  logic coll_d;

  assign run    = (state_q == ST_RUN);
  assign wr0    = run && !csb0 && !web0;
  assign rd0    = run && !csb0 &&  web0;
  assign rd1    = run && !csb1;
  assign coll_d = wr0 && rd1 && (addr0 == addr1) && (wmask0 != '0);

  // clear sequencer: state and sweep pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // clear sequencer: sweep every address once, then enter normal operation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign ready = run;

  // write source: the clear sweep owns the write port while it runs
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NUM_WMASKS-1:0] wlanes;

  // select between clear-sweep writes and masked port 0 writes
  always_comb begin
    waddr  = addr0;
    wdata  = din0;
    wlanes = '0;
    if (state_q == ST_INIT) begin
      waddr  = ptr_q;
      wdata  = INIT_VALUE;
      wlanes = '1;
    end else if (wr0) begin
      wlanes = wmask0;
    end
  end

  // storage array, written lane by lane so byte enables map onto RAM primitives
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_WMASKS); i++) begin
      if (wlanes[i]) begin
        mem_q[waddr][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  // port 1 read word, optionally forwarding the lanes being written this cycle
  logic [DATA_WIDTH-1:0] rd1_old;
  logic [DATA_WIDTH-1:0] rd1_word;

  assign rd1_old = mem_q[addr1];

  generate
    if (RDW_NEW) begin : g_rdw_new
      // merge the written lanes into the old word on a same-address collision
      always_comb begin
        rd1_word = rd1_old;
        if (coll_d) begin
          for (int i = 0; i < int'(NUM_WMASKS); i++) begin
            if (wmask0[i]) begin
              rd1_word[i*MASK_GRAN +: MASK_GRAN] = din0[i*MASK_GRAN +: MASK_GRAN];
            end
          end
        end
      end
    end else begin : g_rdw_old
      assign rd1_word = rd1_old;
    end
  endgenerate

  // first output stage: read data (held when idle), valids and collision stats
  logic [DATA_WIDTH-1:0] dout0_s1_q;
  logic [DATA_WIDTH-1:0] dout1_s1_q;
  logic                  dv0_s1_q;
  logic                  dv1_s1_q;
  logic                  coll_q;
  logic [15:0]           coll_cnt_q;

  // capture reads and count collisions with a saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0_s1_q <= '0;
      dout1_s1_q <= '0;
      dv0_s1_q   <= 1'b0;
      dv1_s1_q   <= 1'b0;
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      dv0_s1_q <= rd0;
      dv1_s1_q <= rd1;
      if (rd0) begin
        dout0_s1_q <= mem_q[addr0];
      end
      if (rd1) begin
        dout1_s1_q <= rd1_word;
      end
      coll_q <= coll_d;
      if (coll_d && (coll_cnt_q != CNT_MAX)) begin
        coll_cnt_q <= coll_cnt_q + 16'd1;
      end
    end
  end

  assign coll     = coll_q;
  assign coll_cnt = coll_cnt_q;

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout0_s2_q;
      logic [DATA_WIDTH-1:0] dout1_s2_q;
      logic                  dv0_s2_q;
      logic                  dv1_s2_q;

      // second output stage: data and valid delayed together by one edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout0_s2_q <= '0;
          dout1_s2_q <= '0;
          dv0_s2_q   <= 1'b0;
          dv1_s2_q   <= 1'b0;
        end else begin
          dv0_s2_q <= dv0_s1_q;
          dv1_s2_q <= dv1_s1_q;
          if (dv0_s1_q) begin
            dout0_s2_q <= dout0_s1_q;
          end
          if (dv1_s1_q) begin
            dout1_s2_q <= dout1_s1_q;
          end
        end
      end

      assign dout0   = dout0_s2_q;
      assign dout1   = dout1_s2_q;
      assign dvalid0 = dv0_s2_q;
      assign dvalid1 = dv1_s2_q;
    end else begin : g_no_out_reg
      assign dout0   = dout0_s1_q;
      assign dout1   = dout1_s1_q;
      assign dvalid0 = dv0_s1_q;
      assign dvalid1 = dv1_s1_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_1rw1r_param
// Description : Self-checking bench for sram_1rw1r_param. Three instances
//               (old-data RDW, new-data RDW, registered outputs) share one
//               stimulus stream and are compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1rw1r_param;

  localparam int          DEPTH    = 16;
  localparam logic [31:0] INIT_VAL = 32'h5A5A_C3C3;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        csb0   = 1'b1;
  logic        web0   = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [3:0]  addr0  = '0;
  logic [31:0] din0   = '0;
  logic        csb1   = 1'b1;
  logic [3:0]  addr1  = '0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1, c_dout0, c_dout1;
  logic        a_dv0, a_dv1, b_dv0, b_dv1, c_dv0, c_dv1;
  logic        a_ready, b_ready, c_ready, a_coll, b_coll, c_coll;
  logic [15:0] a_cnt, b_cnt, c_cnt;

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MASK_GRAN(8), .OUT_REG(1'b0),
                     .RDW_NEW(1'b0), .INIT_VALUE(INIT_VAL)) u_a (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_dout0), .dvalid0(a_dv0), .csb1(csb1), .addr1(addr1),
    .dout1(a_dout1), .dvalid1(a_dv1), .ready(a_ready), .coll(a_coll), .coll_cnt(a_cnt));

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MASK_GRAN(8), .OUT_REG(1'b0),
                     .RDW_NEW(1'b1), .INIT_VALUE(INIT_VAL)) u_b (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_dout0), .dvalid0(b_dv0), .csb1(csb1), .addr1(addr1),
    .dout1(b_dout1), .dvalid1(b_dv1), .ready(b_ready), .coll(b_coll), .coll_cnt(b_cnt));

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MASK_GRAN(8), .OUT_REG(1'b1),
                     .RDW_NEW(1'b0), .INIT_VALUE(INIT_VAL)) u_c (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(c_dout0), .dvalid0(c_dv0), .csb1(csb1), .addr1(addr1),
    .dout1(c_dout1), .dvalid1(c_dv1), .ready(c_ready), .coll(c_coll), .coll_cnt(c_cnt));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mem [DEPTH];
  int          init_cnt;
  logic [31:0] e_d0, e_d1a, e_d1b, e2_d0, e2_d1;
  logic        e_v0, e_v1, e2_v0, e2_v1, e_coll, e_ready;
  logic [15:0] e_cnt;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  task automatic model_reset();
    init_cnt = 0;
    e_d0 = '0; e_d1a = '0; e_d1b = '0; e2_d0 = '0; e2_d1 = '0;
    e_v0 = 1'b0; e_v1 = 1'b0; e2_v0 = 1'b0; e2_v1 = 1'b0;
    e_coll = 1'b0; e_ready = 1'b0; e_cnt = '0;
  endtask

  // one clock: model evaluates the request present at the edge, return #1 later
  task automatic tick();
    logic        wr, rd0, rd1, col;
    logic [31:0] old1;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      e2_v0 = e_v0; if (e_v0) e2_d0 = e_d0;
      e2_v1 = e_v1; if (e_v1) e2_d1 = e_d1a;
      if (init_cnt < DEPTH) begin
        m_mem[init_cnt] = INIT_VAL;
        init_cnt++;
        e_v0 = 1'b0; e_v1 = 1'b0; e_coll = 1'b0;
      end else begin
        wr   = !csb0 && !web0;
        rd0  = !csb0 && web0;
        rd1  = !csb1;
        col  = wr && rd1 && (addr0 == addr1) && (wmask0 != 4'd0);
        old1 = m_mem[addr1];
        e_v0 = rd0;
        if (rd0) e_d0 = m_mem[addr0];
        e_v1 = rd1;
        if (rd1) begin
          e_d1a = old1;
          e_d1b = col ? merge(old1, din0, wmask0) : old1;
        end
        e_coll = col;
        if (col && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        if (wr) m_mem[addr0] = merge(m_mem[addr0], din0, wmask0);
      end
      e_ready = (init_cnt == DEPTH);
    end
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic write0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    n_checks++;
    if ({a_dout0, a_dv0, a_dout1, a_dv1, a_ready, a_coll, a_cnt} !== '0)
      $display("FAIL reset_a: got %h want 0", {a_dout0, a_dv0, a_dout1, a_dv1, a_ready, a_coll, a_cnt});
    else n_pass++;
    n_checks++;
    if ({b_dout0, b_dv0, b_dout1, b_dv1, b_ready, b_coll, b_cnt} !== '0)
      $display("FAIL reset_b: got %h want 0", {b_dout0, b_dv0, b_dout1, b_dv1, b_ready, b_coll, b_cnt});
    else n_pass++;
    n_checks++;
    if ({c_dout0, c_dv0, c_dout1, c_dv1, c_ready, c_coll, c_cnt} !== '0)
      $display("FAIL reset_c: got %h want 0", {c_dout0, c_dv0, c_dout1, c_dv1, c_ready, c_coll, c_cnt});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  // requests issued while clearing must be ignored; then every word reads INIT_VAL
  task automatic test_init_sweep();
    for (int k = 1; k <= DEPTH; k++) begin
      write0(4'd2, 32'hFFFF_FFFF, 4'hF);
      csb1 = 1'b0; addr1 = 4'(k);
      tick();
      n_checks++;
      if (a_ready !== (k == DEPTH) || a_dv0 !== 1'b0 || a_dv1 !== 1'b0 || a_coll !== 1'b0 || c_dv1 !== 1'b0)
        $display("FAIL init_sweep cyc %0d: ready=%b dv0=%b dv1=%b coll=%b want ready=%b dv=0 coll=0",
                 k, a_ready, a_dv0, a_dv1, a_coll, (k == DEPTH));
      else n_pass++;
    end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      csb1 = 1'b0; addr1 = 4'(i);
      tick();
      n_checks++;
      if (a_dout1 !== INIT_VAL || a_dv1 !== 1'b1 || b_dout1 !== INIT_VAL)
        $display("FAIL init_read addr %0d: got %h/%b want %h/1", i, a_dout1, a_dv1, INIT_VAL);
      else n_pass++;
    end
    idle();
    tick();
    n_checks++;
    if (a_dv1 !== 1'b0 || a_dout1 !== INIT_VAL)
      $display("FAIL deselect_hold: got %h/%b want %h/0", a_dout1, a_dv1, INIT_VAL);
    else n_pass++;
  endtask

  task automatic test_masked_write();
    write0(4'd5, 32'hDEAD_BEEF, 4'b1111); tick();
    write0(4'd5, 32'h1122_3344, 4'b0101); tick();
    n_checks++;
    if (a_dv0 !== 1'b0) $display("FAIL write_no_dvalid: got %b want 0", a_dv0);
    else n_pass++;
    idle(); csb0 = 1'b0; addr0 = 4'd5; tick();
    n_checks++;
    if (a_dout0 !== 32'hDE22_BE44 || a_dv0 !== 1'b1)
      $display("FAIL mask_merge: got %h/%b want de22be44/1", a_dout0, a_dv0);
    else n_pass++;
    write0(4'd5, 32'h0000_0000, 4'b0000); tick();
    n_checks++;
    if (a_dout0 !== 32'hDE22_BE44 || a_dv0 !== 1'b0)
      $display("FAIL write_dout_hold: got %h/%b want de22be44/0", a_dout0, a_dv0);
    else n_pass++;
    idle(); csb0 = 1'b0; addr0 = 4'd5; tick();
    n_checks++;
    if (a_dout0 !== 32'hDE22_BE44 || a_dout0 !== e_d0)
      $display("FAIL mask_zero_noop: got %h want de22be44", a_dout0);
    else n_pass++;
    idle();
  endtask

  task automatic test_collision();
    write0(4'd3, 32'h1234_5678, 4'hF); tick();
    write0(4'd3, 32'hAAAA_AAAA, 4'b0011); csb1 = 1'b0; addr1 = 4'd3; tick();
    n_checks++;
    if (a_dout1 !== 32'h1234_5678) $display("FAIL rdw_old: got %h want 12345678", a_dout1);
    else n_pass++;
    n_checks++;
    if (b_dout1 !== 32'h1234_AAAA) $display("FAIL rdw_new: got %h want 1234aaaa", b_dout1);
    else n_pass++;
    n_checks++;
    if (a_coll !== 1'b1 || b_coll !== 1'b1 || c_coll !== 1'b1 || a_cnt !== 16'd1 || c_cnt !== 16'd1)
      $display("FAIL coll_pulse: got coll=%b cnt=%0d want 1/1", a_coll, a_cnt);
    else n_pass++;
    idle(); tick();
    n_checks++;
    if (a_coll !== 1'b0 || a_cnt !== 16'd1 || c_dout1 !== 32'h1234_5678 || c_dv1 !== 1'b1)
      $display("FAIL coll_after: coll=%b cnt=%0d c_dout1=%h c_dv1=%b want 0/1/12345678/1",
               a_coll, a_cnt, c_dout1, c_dv1);
    else n_pass++;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3; csb1 = 1'b0; addr1 = 4'd3; tick();
    n_checks++;
    if (a_dout0 !== 32'h1234_AAAA || a_dout1 !== 32'h1234_AAAA || a_coll !== 1'b0 || a_dv0 !== 1'b1)
      $display("FAIL dual_read: got %h/%h coll=%b want 1234aaaa/1234aaaa coll=0", a_dout0, a_dout1, a_coll);
    else n_pass++;
    write0(4'd3, 32'h5555_5555, 4'b0000); csb1 = 1'b0; addr1 = 4'd3; tick();
    write0(4'd4, 32'h5555_5555, 4'b1111); csb1 = 1'b0; addr1 = 4'd3; tick();
    n_checks++;
    if (a_coll !== 1'b0 || a_cnt !== 16'd1 || b_dout1 !== 32'h1234_AAAA)
      $display("FAIL no_coll_cases: coll=%b cnt=%0d b_dout1=%h want 0/1/1234aaaa", a_coll, a_cnt, b_dout1);
    else n_pass++;
    idle();
  endtask

  task automatic test_outreg();
    idle(); tick();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd7; tick();
    n_checks++;
    if (c_dv0 !== 1'b0 || a_dv0 !== 1'b1)
      $display("FAIL outreg_lat_n1: c_dv0=%b a_dv0=%b want 0/1", c_dv0, a_dv0);
    else n_pass++;
    idle(); tick();
    n_checks++;
    if (c_dv0 !== 1'b1 || c_dout0 !== INIT_VAL)
      $display("FAIL outreg_lat_n2: got %h/%b want %h/1", c_dout0, c_dv0, INIT_VAL);
    else n_pass++;
    for (int i = 8; i < 12; i++) begin
      write0(4'(i), {4{8'(i)}} ^ 32'hC0DE_0000, 4'hF); tick();
    end
    for (int i = 8; i < 13; i++) begin
      idle();
      if (i < 12) begin csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(i); end
      tick();
      if (i > 8) begin
        n_checks++;
        if (c_dv0 !== 1'b1 || c_dout0 !== ({4{8'(i - 1)}} ^ 32'hC0DE_0000))
          $display("FAIL outreg_stream addr %0d: got %h/%b want %h/1", i - 1, c_dout0, c_dv0,
                   {4{8'(i - 1)}} ^ 32'hC0DE_0000);
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = 1'($urandom_range(0, 1));
      wmask0 = 4'($urandom_range(0, 15));
      addr0  = 4'($urandom_range(0, 3));
      din0   = $urandom;
      csb1   = ($urandom_range(0, 3) == 0);
      addr1  = 4'($urandom_range(0, 3));
      tick();
      n_checks++;
      if ({a_dout0, a_dv0, a_dout1, a_dv1, a_ready, a_coll, a_cnt} !== {e_d0, e_v0, e_d1a, e_v1, e_ready, e_coll, e_cnt})
        $display("FAIL rand_a cyc %0d: got %h want %h", i, {a_dout0, a_dv0, a_dout1, a_dv1, a_ready, a_coll, a_cnt},
                 {e_d0, e_v0, e_d1a, e_v1, e_ready, e_coll, e_cnt});
      else n_pass++;
      n_checks++;
      if ({b_dout0, b_dv0, b_dout1, b_dv1, b_ready, b_coll, b_cnt} !== {e_d0, e_v0, e_d1b, e_v1, e_ready, e_coll, e_cnt})
        $display("FAIL rand_b cyc %0d: got %h want %h", i, {b_dout0, b_dv0, b_dout1, b_dv1, b_ready, b_coll, b_cnt},
                 {e_d0, e_v0, e_d1b, e_v1, e_ready, e_coll, e_cnt});
      else n_pass++;
      n_checks++;
      if ({c_dout0, c_dv0, c_dout1, c_dv1, c_ready, c_coll, c_cnt} !== {e2_d0, e2_v0, e2_d1, e2_v1, e_ready, e_coll, e_cnt})
        $display("FAIL rand_c cyc %0d: got %h want %h", i, {c_dout0, c_dv0, c_dout1, c_dv1, c_ready, c_coll, c_cnt},
                 {e2_d0, e2_v0, e2_d1, e2_v1, e_ready, e_coll, e_cnt});
      else n_pass++;
    end
    idle();
  endtask

  // reset asserted partway through the clear sweep restarts it from address 0
  task automatic test_reset_mid_init();
    idle();
    rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0; model_reset();
    #1;
    n_checks++;
    if ({a_dout0, a_dv0, a_dout1, a_dv1, a_ready, a_cnt} !== '0)
      $display("FAIL mid_init_async: got %h want 0", {a_dout0, a_dv0, a_dout1, a_dv1, a_ready, a_cnt});
    else n_pass++;
    tick(); rst_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      n_checks++;
      if (a_ready !== (k == DEPTH) || c_ready !== (k == DEPTH))
        $display("FAIL mid_init_ready cyc %0d: got %b want %b", k, a_ready, (k == DEPTH));
      else n_pass++;
    end
    csb1 = 1'b0; addr1 = 4'd5; tick();
    n_checks++;
    if (a_dout1 !== INIT_VAL || a_dv1 !== 1'b1)
      $display("FAIL reclear_addr5: got %h/%b want %h/1", a_dout1, a_dv1, INIT_VAL);
    else n_pass++;
    idle();
  endtask

  task automatic test_saturation_reset();
    write0(4'd1, 32'h0F0F_0F0F, 4'hF); csb1 = 1'b0; addr1 = 4'd1;
    repeat (70000) tick();
    n_checks++;
    if (a_cnt !== 16'hFFFF || b_cnt !== 16'hFFFF || c_cnt !== 16'hFFFF || a_cnt !== e_cnt || a_coll !== 1'b1)
      $display("FAIL coll_saturate: got %h/%h/%h coll=%b want ffff coll=1", a_cnt, b_cnt, c_cnt, a_coll);
    else n_pass++;
    idle(); csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd1; csb1 = 1'b0; addr1 = 4'd1;
    tick();
    rst_n = 1'b0; model_reset(); idle();
    #1;
    n_checks++;
    if ({c_dv0, c_dv1, a_dv0, a_dv1, a_ready, a_coll, a_cnt, c_cnt} !== '0)
      $display("FAIL run_reset_async: got %h want 0", {c_dv0, c_dv1, a_dv0, a_dv1, a_ready, a_coll, a_cnt, c_cnt});
    else n_pass++;
    tick(); rst_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      n_checks++;
      if (a_ready !== (k == DEPTH) || c_dv0 !== 1'b0 || c_dv1 !== 1'b0 || a_cnt !== 16'd0)
        $display("FAIL run_reset_reinit cyc %0d: ready=%b c_dv=%b%b cnt=%h want ready=%b dv=00 cnt=0",
                 k, a_ready, c_dv0, c_dv1, a_cnt, (k == DEPTH));
      else n_pass++;
    end
    csb1 = 1'b0; addr1 = 4'd1; tick();
    n_checks++;
    if (a_dout1 !== INIT_VAL || a_dout1 !== e_d1a)
      $display("FAIL run_reset_reclear: got %h want %h", a_dout1, INIT_VAL);
    else n_pass++;
    idle();
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_masked_write();
    test_collision();
    test_outreg();
    test_random();
    test_reset_mid_init();
    test_saturation_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_1rw1r_param.md
# sram_1rw1r_param

Parametrised, synthesizable dual-port (one read/write, one read-only) SRAM model with byte-lane write masks, a selectable read-during-write policy and a post-reset clear sequencer. It replaces the fixed 32x512 behavioural macro wherever the design needs a different geometry, deterministic contents after reset, or cycle-accurate port-collision behaviour in simulation and FPGA builds. Both ports run on a single clock.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of MASK_GRAN
- ADDR_WIDTH, 9, address bits; depth = 2^ADDR_WIDTH
- MASK_GRAN, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/MASK_GRAN
- OUT_REG, 0, 1 adds a second output register stage (read latency 2 instead of 1)
- RDW_NEW, 0, port-1 result on same-address collision: 0 = old data, 1 = newly written data (mask-merged)
- INIT_VALUE, 0, word written to every location by the clear sequencer
- clk  in  1  single clock, all ports
- rst_n  in  1  asynchronous, active-low reset
- csb0  in  1  port 0 select, active low
- web0  in  1  port 0 write enable, active low
- wmask0  in  NUM_WMASKS  per-lane write enable, active high
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- dvalid0  out  1  dout0 carries fresh read data this cycle
- csb1  in  1  port 1 select, active low
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data
- dvalid1  out  1  dout1 carries fresh read data this cycle
- ready  out  1  clear sequence complete; requests accepted only when high
- coll  out  1  one-cycle pulse: collision detected
- coll_cnt  out  16  saturating collision count

## Operation
- States: INIT, RUN. rst_n low forces INIT, sweep pointer 0.
- INIT: each cycle writes INIT_VALUE to mem[ptr], ptr++; after writing address 2^ADDR_WIDTH-1 moves to RUN. ready = (state == RUN).
- In INIT all port requests ignored: no write, dvalid0/dvalid1 stay 0, no collision counted.
- RUN, port 0 write (csb0=0, web0=0): lane i of mem[addr0] <= din0 lane i where wmask0[i]=1; wmask0=0 is a no-op. dout0 holds; dvalid0 = 0.
- RUN, port 0 read (csb0=0, web0=1): dout0 <= mem[addr0], dvalid0 pulses.
- RUN, port 1 read (csb1=0): dout1 <= mem[addr1], dvalid1 pulses.
- Collision: port 0 write and port 1 read in the same cycle with addr0 == addr1 and wmask0 != 0. coll pulses; coll_cnt increments, saturates at 16'hFFFF. dout1 = old word (RDW_NEW=0) or old word with masked lanes replaced by din0 (RDW_NEW=1).
- Both ports reading the same address: no collision, both return the word.
- Deselected port: dout holds last value, dvalid 0.

## Timing
- Requests sampled at posedge. OUT_REG=0: dout/dvalid updated at the same edge (latency 1). OUT_REG=1: one additional edge (latency 2); dvalid delayed identically.
- Write visible to a read issued on the following cycle (either port).
- Back-to-back requests every cycle on both ports; no stalls in RUN.
- INIT lasts exactly 2^ADDR_WIDTH cycles after rst_n deasserts; ready rises at the edge after the last clear write.
- Reset values: dout0 = 0, dout1 = 0, dvalid0 = 0, dvalid1 = 0, ready = 0, coll = 0, coll_cnt = 0; OUT_REG pipeline stages cleared.
- rst_n asserted mid-INIT or mid-RUN: immediate return to INIT, ptr = 0, in-flight reads discarded (dvalid never asserted for them); memory re-cleared.

## Test plan
- Reset release, ADDR_WIDTH=4: ready low for 16 cycles then high; read all 16 addresses on port 1 -> each returns INIT_VALUE, dvalid1 one cycle after each request (OUT_REG=0).
- Write 32'hDEADBEEF to addr 5 with wmask0=4'b1111, then wmask0=4'b0101 with 32'h11223344 -> read returns 32'hDE22BE44; wmask0=0 write -> unchanged.
- Same-cycle write 32'hAAAAAAAA (mask 4'b0011) and port-1 read at addr 3 holding 32'h12345678: RDW_NEW=0 -> dout1 = 32'h12345678; RDW_NEW=1 -> 32'h1234AAAA; coll pulses, coll_cnt = 1.
- Requests during INIT (write addr 2 with 32'hFFFFFFFF): no dvalid, addr 2 reads INIT_VALUE after ready.
- OUT_REG=1: read addr 7 at cycle N -> dvalid0 and data at cycle N+2; back-to-back reads stream one word per cycle.
- Assert rst_n low midway through INIT and after 70000 forced collisions: ptr restarts, ready low 2^ADDR_WIDTH cycles, coll_cnt = 0; pre-reset saturation shows coll_cnt = 16'hFFFF.
